// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of a shared combinational ALU
//
// Purpose:
//   Accepts one operation at a time from two requesters and drives its
//   operands to an external combinational ALU. The ALU result is captured
//   one cycle later and returned on the granted requester's response channel.
//   Arbitration is round-robin (RR_EN=1) or fixed priority to requester 0
//   (RR_EN=0). There is exactly one operation in flight at a time, so the
//   minimum issue interval is three cycles (IDLE -> EXEC -> RESP).
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   reqN_valid / reqN_ready    request handshake for requester N (ready is combinational)
//   reqN_a, reqN_b, reqN_aluc  operands and opcode of requester N
//   rspN_valid / rspN_ready    response handshake for requester N
//   rsp_out, rsp_zero          captured ALU result and zero flag (shared by both channels)
//   alu_a, alu_b, alu_aluc     registered operands/opcode to the shared ALU
//   alu_out, alu_zero          result and zero flag from the shared ALU
//   busy                       high whenever an operation is in flight

module alu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_aluc,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_aluc,

  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_out,
  output logic        rsp_zero,

  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_aluc,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,

  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        grant_idx;   // requester owning the in-flight operation
  logic        last_grant;  // requester granted most recently (round-robin pointer)
  logic        win_idx;     // arbitration winner among currently valid requesters
  logic        any_valid;
  logic        accept;      // IDLE-cycle request handshake
  logic        rsp_hs;      // RESP-cycle response handshake on the granted channel

  logic [31:0] win_a;
  logic [31:0] win_b;
  logic [2:0]  win_aluc;

  // Arbitration. On a tie, round-robin picks whoever was not granted last;
  // last_grant resets to 1 so requester 0 wins the first tie.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    win_idx   = 1'b0;
    if (req0_valid && req1_valid) begin
      win_idx = RR_EN ? ~last_grant : 1'b0;
    end else if (req1_valid) begin
      win_idx = 1'b1;
    end
  end

  // Operand select for the winner.
  always_comb begin
    win_a    = req0_a;
    win_b    = req0_b;
    win_aluc = req0_aluc;
    if (win_idx) begin
      win_a    = req1_a;
      win_b    = req1_b;
      win_aluc = req1_aluc;
    end
  end

  // Handshake qualifiers. Ready is gated by rst_n so nothing is offered
  // while reset is held, even if the state register has not yet cleared.
  always_comb begin
    accept = rst_n && (state == IDLE) && any_valid;
    rsp_hs = (state == RESP) && (grant_idx ? rsp1_ready : rsp0_ready);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. EXEC always lasts exactly one cycle; RESP waits for
  // the granted requester's rsp_ready, stalling the arbiter indefinitely.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    req0_ready = accept & ~win_idx;
    req1_ready = accept &  win_idx;
    rsp0_valid = (state == RESP) & ~grant_idx;
    rsp1_valid = (state == RESP) &  grant_idx;
    busy       = (state != IDLE);
  end

  // Datapath registers. Operands are latched only on accept so later changes
  // on the request inputs cannot disturb the in-flight operation; the result
  // is captured only in EXEC so it stays stable through RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a      <= 32'd0;
      alu_b      <= 32'd0;
      alu_aluc   <= 3'b000;
      rsp_out    <= 32'd0;
      rsp_zero   <= 1'b0;
      grant_idx  <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (accept) begin
        alu_a     <= win_a;
        alu_b     <= win_b;
        alu_aluc  <= win_aluc;
        grant_idx <= win_idx;
      end
      if (state == EXEC) begin
        rsp_out  <= alu_out;
        rsp_zero <= alu_zero;
      end
      if (rsp_hs) begin
        last_grant <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a transaction-level model
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_aluc, req1_aluc;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp_out;
  logic        rsp_zero;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_aluc;
  logic        alu_zero;
  logic        busy;

  logic        f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid;
  logic [31:0] f_rsp_out, f_alu_a, f_alu_b, f_alu_out;
  logic        f_rsp_zero, f_alu_zero, f_busy;
  logic [2:0]  f_alu_aluc;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  c;
  } op_t;

  typedef struct {
    bit          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  c;
    logic [31:0] res;
  } exp_t;

  op_t  q0[$];
  op_t  q1[$];
  exp_t exp_q[$];

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  bit rst_drive = 1'b0;
  bit rr0 = 1'b1, rr1 = 1'b1, rr_rand = 1'b0;
  bit pop0 = 1'b0, pop1 = 1'b0, acc0 = 1'b0;
  bit tie_win = 1'b0;
  int f_hs = 0;

  // Reference ALU used both as the DUT's external ALU and for expected results.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    case (c)
      3'b000:  return a + b;
      3'b001:  return a & b;
      3'b010:  return a | b;
      3'b011:  return a ^ b;
      3'b100:  return a - b;
      3'b101:  return a << b[4:0];
      3'b110:  return a >> b[4:0];
      default: return (a == b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  assign alu_out    = alu_fn(alu_a, alu_b, alu_aluc);
  assign alu_zero   = (alu_out == 32'd0);
  assign f_alu_out  = alu_fn(f_alu_a, f_alu_b, f_alu_aluc);
  assign f_alu_zero = (f_alu_out == 32'd0);

  alu_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_aluc(req0_aluc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_aluc(req1_aluc),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_out(rsp_out), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_out(alu_out), .alu_zero(alu_zero),
    .busy(busy)
  );

  alu_arbiter #(.RR_EN(1'b0)) dut_fixed (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_aluc(req0_aluc),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_aluc(req1_aluc),
    .rsp0_valid(f_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(f_rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_out(f_rsp_out), .rsp_zero(f_rsp_zero),
    .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_aluc(f_alu_aluc), .alu_out(f_alu_out), .alu_zero(f_alu_zero),
    .busy(f_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, expv);
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.a = $urandom();
    o.b = ($urandom_range(0, 3) == 0) ? o.a : $urandom();
    o.c = 3'($urandom_range(0, 7));
    return o;
  endfunction

  function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    op_t o;
    o.a = a; o.b = b; o.c = c;
    return o;
  endfunction

  // One clock: drive after the rising edge, observe handshakes at the falling edge.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst_drive;
    if (pop0) void'(q0.pop_front());
    if (pop1) void'(q1.pop_front());
    pop0 = 1'b0; pop1 = 1'b0; acc0 = 1'b0;
    req0_valid = (q0.size() > 0);
    req1_valid = (q1.size() > 0);
    if (q0.size() > 0) begin req0_a = q0[0].a; req0_b = q0[0].b; req0_aluc = q0[0].c; end
    else begin req0_a = $urandom(); req0_b = $urandom(); req0_aluc = 3'($urandom_range(0, 7)); end
    if (q1.size() > 0) begin req1_a = q1[0].a; req1_b = q1[0].b; req1_aluc = q1[0].c; end
    else begin req1_a = $urandom(); req1_b = $urandom(); req1_aluc = 3'($urandom_range(0, 7)); end
    rsp0_ready = rr_rand ? ($urandom_range(0, 3) != 0) : rr0;
    rsp1_ready = rr_rand ? ($urandom_range(0, 3) != 0) : rr1;
    @(negedge clk);
    if (rst_n && req0_valid && req0_ready) begin
      e.idx = 1'b0; e.a = req0_a; e.b = req0_b; e.c = req0_aluc; e.res = alu_fn(req0_a, req0_b, req0_aluc);
      exp_q.push_back(e);
      pop0 = 1'b1; acc0 = 1'b1;
    end
    if (rst_n && req1_valid && req1_ready) begin
      e.idx = 1'b1; e.a = req1_a; e.b = req1_b; e.c = req1_aluc; e.res = alu_fn(req1_a, req1_b, req1_aluc);
      exp_q.push_back(e);
      pop1 = 1'b1;
    end
  endtask

  task automatic drain(input string nm);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      step();
      if (q0.size() == 0 && q1.size() == 0 && !pop0 && !pop1 && !busy && exp_q.size() == 0) done = 1'b1;
    end
    if (!done) chk(1'b0, nm, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: transaction-level model of the arbiter. One operation in flight,
  // accepted when free, response due two cycles after acceptance.
  initial begin : monitor
    bit       m_infl = 1'b0;
    bit       m_last = 1'b1;
    bit       m_idx = 1'b0;
    int       m_acc = 0;
    bit       after_rst = 1'b0;
    bit       e0, e1, win, do_acc;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        chk({req1_ready, req0_ready} == 2'b00, "ready_in_reset", 32'({req1_ready, req0_ready}), 32'd0);
        m_infl = 1'b0; m_last = 1'b1;
        exp_q.delete();
        after_rst = 1'b1;
      end else begin
        if (after_rst) begin
          chk(alu_a == 0 && alu_b == 0 && alu_aluc == 0, "reset_alu_regs", alu_a | alu_b | 32'(alu_aluc), 32'd0);
          chk(rsp_out == 0 && !rsp_zero, "reset_rsp_data", rsp_out | 32'(rsp_zero), 32'd0);
          chk(!rsp0_valid && !rsp1_valid && !busy, "reset_flags", 32'({busy, rsp1_valid, rsp0_valid}), 32'd0);
          after_rst = 1'b0;
        end
        e0 = 1'b0; e1 = 1'b0; do_acc = 1'b0; win = 1'b0;
        if (!m_infl && (req0_valid || req1_valid)) begin
          if (req0_valid && req1_valid) win = (m_last == 1'b0);
          else win = req1_valid;
          do_acc = 1'b1;
          if (win) e1 = 1'b1; else e0 = 1'b1;
        end
        chk({req1_ready, req0_ready} == {e1, e0}, "arb_ready", 32'({req1_ready, req0_ready}), 32'({e1, e0}));
        chk(busy == m_infl, "busy", 32'(busy), 32'(m_infl));
        if (m_infl && cyc == m_acc + 1 && exp_q.size() > 0) begin
          chk(alu_a == exp_q[0].a && alu_b == exp_q[0].b && alu_aluc == exp_q[0].c, "alu_operands",
              alu_a ^ alu_b ^ 32'(alu_aluc), exp_q[0].a ^ exp_q[0].b ^ 32'(exp_q[0].c));
        end
        if (m_infl && cyc >= m_acc + 2) begin
          chk({rsp1_valid, rsp0_valid} == (m_idx ? 2'b10 : 2'b01), "rsp_valid",
              32'({rsp1_valid, rsp0_valid}), m_idx ? 32'd2 : 32'd1);
          if (exp_q.size() == 0) begin
            chk(1'b0, "scoreboard_empty", 32'd0, 32'd1);
          end else begin
            chk(exp_q[0].idx == m_idx, "grant_idx", 32'(m_idx), 32'(exp_q[0].idx));
            chk(rsp_out == exp_q[0].res, "rsp_out", rsp_out, exp_q[0].res);
            chk(rsp_zero == (exp_q[0].res == 0), "rsp_zero", 32'(rsp_zero), 32'(exp_q[0].res == 0));
          end
          if (m_idx ? rsp1_ready : rsp0_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            m_last = m_idx;
            m_infl = 1'b0;
          end
        end else begin
          chk(!rsp0_valid && !rsp1_valid, "rsp_idle", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        end
        if (do_acc) begin
          m_infl = 1'b1; m_idx = win; m_acc = cyc;
        end
        if (tie_win) begin
          chk(!f_req1_ready && !f_rsp1_valid, "fixed_prio_req1", 32'({f_rsp1_valid, f_req1_ready}), 32'd0);
          if (f_rsp0_valid && rsp0_ready) f_hs++;
        end
      end
    end
  end

  initial begin : stimulus
    bit seen;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_aluc = '0;
    req1_a = '0; req1_b = '0; req1_aluc = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (3) step();
    rst_drive = 1'b1;

    // Single op on requester 0, then zero-flag cases on requester 1.
    q0.push_back(mk(32'd5, 32'd3, 3'b000));
    drain("drain_single");
    q1.push_back(mk(32'd4, 32'd4, 3'b100));
    q1.push_back(mk(32'd7, 32'd7, 3'b111));
    drain("drain_zero");

    // Tie right after reset: round-robin alternates, fixed priority always picks 0.
    rst_drive = 1'b0;
    for (int i = 0; i < 4; i++) begin q0.push_back(rand_op()); q1.push_back(rand_op()); end
    repeat (2) step();
    rst_drive = 1'b1;
    f_hs = 0;
    tie_win = 1'b1;
    repeat (10) step();
    tie_win = 1'b0;
    chk(f_hs == 3, "fixed_prio_count", 32'(f_hs), 32'd3);
    drain("drain_tie");

    // Backpressure on requester 0 while requester 1 waits.
    q0.push_back(rand_op());
    q1.push_back(rand_op());
    rr0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin step(); seen = rsp0_valid; end
    chk(seen, "bp_rsp0_seen", 32'(seen), 32'd1);
    repeat (4) step();
    rr0 = 1'b1;
    drain("drain_bp");

    // Reset while in EXEC discards the operation; a new one then completes normally.
    q0.push_back(rand_op());
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin step(); seen = acc0; end
    chk(seen, "mid_reset_accept", 32'(seen), 32'd1);
    rst_drive = 1'b0;
    step();
    rst_drive = 1'b1;
    q0.push_back(mk(32'd10, 32'd20, 3'b000));
    drain("drain_mid_reset");

    // Random traffic with random response backpressure.
    rr_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (q0.size() < 3 && $urandom_range(0, 2) == 0) q0.push_back(rand_op());
      if (q1.size() < 3 && $urandom_range(0, 2) == 0) q1.push_back(rand_op());
      step();
    end
    rr_rand = 1'b0;
    drain("drain_random");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: RR_EN, default 1, 1 = round-robin arbitration, 0 = fixed priority (requester 0 always wins).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-005 req0_ready / req1_ready  output  1  requester n operation accepted this cycle (combinational).
REQ-006 req0_a, req0_b / req1_a, req1_b  input  32  operands.
REQ-007 req0_aluc / req1_aluc  input  3  ALU opcode, passed through uninterpreted.
REQ-008 rsp0_valid / rsp1_valid  output  1  result for requester n available.
REQ-009 rsp0_ready / rsp1_ready  input  1  requester n consumes result.
REQ-010 rsp_out  output  32  captured ALU result, shared by both response channels.
REQ-011 rsp_zero  output  1  captured ALU zero flag.
REQ-012 alu_a, alu_b  output  32  operands to the shared ALU (registered).
REQ-013 alu_aluc  output  3  opcode to the shared ALU (registered).
REQ-014 alu_out  input  32  result from the combinational ALU.
REQ-015 alu_zero  input  1  zero flag from the ALU.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-018 In IDLE, the controller SHALL assert req_ready to exactly one requester: the arbitration winner among valid requesters; no ready when neither is valid.
REQ-019 Arbitration SHALL be as follows: one valid requester wins; both valid -> RR_EN=1: requester not granted last; RR_EN=0: requester 0.
REQ-020 On the IDLE cycle where valid&ready is true, the controller SHALL latch winner's a, b, aluc into alu_a/alu_b/alu_aluc, record the grant index, and go to EXEC.
REQ-021 In EXEC (exactly one cycle), the controller SHALL capture alu_out into rsp_out and alu_zero into rsp_zero at the clock edge, then go to RESP.
REQ-022 In RESP, the controller SHALL assert rsp_valid only for the granted requester; rsp_out/rsp_zero SHALL stay stable until handshake.
REQ-023 On a RESP cycle with rsp_valid&rsp_ready, the controller SHALL clear rsp_valid next cycle, update last-grant to the granted index, and go to IDLE.
REQ-024 Latency: the accept edge is T. State SHALL be EXEC in cycle T+1 and rsp_valid SHALL be high in cycle T+2. Minimum issue interval SHALL be 3 cycles.
REQ-025 req_ready SHALL be low in EXEC and RESP; requests arriving then SHALL wait, with no loss or reordering within a requester.
REQ-026 A requester whose rsp_ready is held low SHALL stall the arbiter in RESP indefinitely; the other requester SHALL NOT be granted meanwhile.
REQ-027 alu_a/alu_b/alu_aluc SHALL hold the last latched values outside accept cycles.
REQ-028 rsp_ready on the non-granted channel SHALL be ignored.
REQ-029 Operand/opcode changes on a requester after acceptance SHALL NOT affect the in-flight operation.

Reset
REQ-030 With rst_n low at a rising edge, the controller SHALL set state=IDLE, last-grant=1 (so requester 0 wins the first tie), and clear all outputs: alu_a=0, alu_b=0, alu_aluc=000, rsp_out=0, rsp_zero=0, rsp0/1_valid=0, busy=0.
REQ-031 While rst_n is low, the controller SHALL hold req0/1_ready at 0.
REQ-032 Reset in EXEC or RESP SHALL discard the in-flight operation and produce no response.

Verification
REQ-033 Single op: req0 a=5, b=3, aluc=000 accepted at T -> rsp0_valid at T+2, rsp_out=8, rsp_zero=0; rsp1_valid stays 0.
REQ-034 Zero flag: req1 a=4, b=4, aluc=100 -> rsp1_valid, rsp_out=0, rsp_zero=1; then aluc=111, a=7, b=7 -> rsp_out=1, rsp_zero=0.
REQ-035 Tie after reset, RR_EN=1: both valid continuously, rsp_ready=1 -> grant order 0,1,0,1, issue every 3 cycles; RR_EN=0 -> order 0,0,0.
REQ-036 Backpressure: rsp0_ready low 4 cycles in RESP -> rsp0_valid and rsp_out held, busy=1, req1_ready=0 throughout; grant to req1 occurs 1 cycle after rsp0 handshake.
REQ-037 Reset mid-operation: rst_n low during EXEC -> next cycle IDLE, all outputs 0, no rsp_valid; a request applied after release is accepted with 2-cycle latency.
